// File: rtl/rr_mux_n_pkg.sv
// Shared definitions for the mux family: mode encodings and a width helper.
package rr_mux_n_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of bits needed to index n items (n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Producer/consumer bundle for rr_mux_n: N channel inputs, one registered output stream.
interface rr_mux_n_if #(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = rr_mux_n_pkg::clog2(N_CH)
);

    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [N_CH*W-1:0]   in_data;
    logic [N_CH-1:0]     in_valid;
    logic [N_CH-1:0]     in_ready;
    logic [W-1:0]        out_data;
    logic [SEL_W-1:0]    out_ch;
    logic                out_valid;
    logic                out_ready;

    // Environment side: drives producers/consumer.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Mux side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_mux_n_arbiter.sv
// Purely combinational rotating-priority arbiter: the search starts at ptr and wraps
// through N-1 back to 0; the first requesting index wins.
module rr_arbiter #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = rr_mux_n_pkg::clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0] cand;
    logic           found;

    // Walk the N candidates in priority order; ptr is always < N so one subtract wraps.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready handshake on every channel and
// a single registered output; fixed-select or round-robin channel choice.
module rr_mux_n
    import rr_mux_n_pkg::*;
#(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = clog2(N_CH)
) (
    input  logic       clk,
    input  logic       rst,
    rr_mux_n_if.slave  bus
);

    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  rr_grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_idx;
    logic             any_grant;
    logic             load_en;
    logic [W-1:0]     sel_data;
    int unsigned      sel_int;

    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [SEL_W-1:0] out_ch_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (SEL_W)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Choose the grant source; an out-of-range sel in fixed mode simply grants nothing.
    always_comb begin
        grant     = '0;
        grant_idx = bus.sel;
        sel_int   = 32'(bus.sel);
        if (bus.mode == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end else if (sel_int < N_CH) begin
            grant[bus.sel] = bus.in_valid[bus.sel];
        end
    end

    assign any_grant = |grant;
    // Register can take a new word when empty or when its word leaves this cycle.
    assign load_en   = !out_valid_q || bus.out_ready;

    assign bus.in_ready = grant & {N_CH{load_en && !rst}};

    // One-hot data select from the granted channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*W +: W];
            end
        end
    end

    // Round-robin pointer advances past the winner only on an accepted rr transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (bus.mode == MODE_RR && load_en && any_grant) begin
            if (grant_idx == SEL_W'(N_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Output register and pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load_en) begin
                out_valid_q <= any_grant;
                if (any_grant) begin
                    out_data_q <= sel_data;
                    out_ch_q   <= grant_idx;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
